imem_loader: RTL



---
 rtl/imem_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into the instruction RAM and
// parks the core on the halt opcode until a program is resident.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int          DEPTH    = 32,
    parameter int          ADDR_W   = 5,
    parameter logic [6:0]  HALT_OPC = 7'b1111111
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              reload,
    input  logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic              cpu_run,
    output logic [ADDR_W:0]   words_loaded,
    output logic              err
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK = 2'd2,
        S_ERROR = 2'd3,
`endif
        S_RUN   = 2'd1
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [31:0]     HALT_WORD = {25'd0, HALT_OPC};

    state_t            state_reg, state_next;
    logic [1:0]        byte_idx_reg, byte_idx_next;
    logic [ADDR_W:0]   words_loaded_reg, words_loaded_next;
    logic [23:0]       word_buf;
    logic [31:0]       full_word;
    logic              accept;
    logic              load_accept;
    logic              word_done;
    logic              last_word;
    logic [31:0]       mem [DEPTH];

    // A reload in the same cycle swallows the byte.
    assign accept      = byte_valid & byte_ready & ~reload;
    assign load_accept = accept && (state_reg == S_LOAD);
    assign word_done   = load_accept && (byte_idx_reg == 2'd3);
    assign full_word   = {byte_data, word_buf};
    assign last_word   = (full_word[6:0] == HALT_OPC) || (words_loaded_reg + 1'b1 == DEPTH_W);

    // Lower three byte lanes of the word being assembled; byte 3 goes straight to RAM.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge CLOCK_50 or negedge reset_n) begin
                if (!reset_n) begin
                    lane_reg <= 8'd0;
                end else if (load_accept && byte_idx_reg == 2'(gi)) begin
                    lane_reg <= byte_data;
                end
            end
            assign word_buf[8*gi +: 8] = lane_reg;
        end
    endgenerate

    always_ff @(posedge CLOCK_50) begin
        if (word_done) begin
            mem[words_loaded_reg[ADDR_W-1:0]] <= full_word;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_reg, csum_next;

    always_comb begin
        csum_next = csum_reg;
        if (reload) begin
            csum_next = 8'd0;
        end else if (load_accept) begin
            csum_next = csum_reg ^ byte_data;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            csum_reg <= 8'd0;
        end else begin
            csum_reg <= csum_next;
        end
    end
`endif

    always_comb begin
        state_next        = state_reg;
        byte_idx_next     = byte_idx_reg;
        words_loaded_next = words_loaded_reg;
        if (reload) begin
            state_next        = S_LOAD;
            byte_idx_next     = 2'd0;
            words_loaded_next = '0;
        end else begin
            case (state_reg)
                S_LOAD: begin
                    if (accept) begin
                        byte_idx_next = byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            words_loaded_next = words_loaded_reg + 1'b1;
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_next = S_CHECK;
`else
                                state_next = S_RUN;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) begin
                        state_next = (byte_data == csum_reg) ? S_RUN : S_ERROR;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= S_LOAD;
            byte_idx_reg     <= 2'd0;
            words_loaded_reg <= '0;
        end else begin
            state_reg        <= state_next;
            byte_idx_reg     <= byte_idx_next;
            words_loaded_reg <= words_loaded_next;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign byte_ready = (state_reg == S_LOAD) || (state_reg == S_CHECK);
    assign err        = (state_reg == S_ERROR);
`else
    assign byte_ready = (state_reg == S_LOAD);
    assign err        = 1'b0;
`endif
    assign cpu_run      = (state_reg == S_RUN);
    assign words_loaded = words_loaded_reg;

    // Only words of the current load are visible, and only once running.
    assign instr = (cpu_run && ({1'b0, pc} < words_loaded_reg)) ? mem[pc] : HALT_WORD;

endmodule
